// File: rtl/contador_programa.sv
// contador_programa: fetch-stage program counter with sequential advance,
// absolute / PC-relative redirects, stall and redirect alignment checking.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_stall      hold PC (pipeline hazard)
//   i_br_taken   redirect request this cycle
//   i_br_rel     1 = PC-relative (o_pc + offset*4), 0 = absolute i_br_target
//   i_br_offset  signed word offset for relative redirects
//   i_br_target  absolute redirect target
//   i_ready      fetch stage accepts o_pc this cycle
//   o_pc         current fetch address (registered)
//   o_pc_plus    o_pc + STEP (combinational, for link-register writes)
//   o_valid      o_pc is a valid fetch request (registered)
//   o_misalign   sticky misaligned-redirect flag (registered)
//   o_fetch_cnt  number of accepted fetches, wraps (registered)
module contador_programa #(
  parameter int unsigned     WIDTH      = 64,
  parameter int unsigned     STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned     OFF_W      = 26,
  parameter int unsigned     CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_br_taken,
  input  logic             i_br_rel,
  input  logic [OFF_W-1:0] i_br_offset,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus,
  output logic             o_valid,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic             valid_q,    valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic             xfer;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] tgt;

  // Word offset sign-extended to a byte displacement.
  assign off_ext = {{(WIDTH-OFF_W){i_br_offset[OFF_W-1]}}, i_br_offset} << 2;
  assign tgt     = i_br_rel ? (pc_q + off_ext) : i_br_target;
  assign xfer    = valid_q & i_ready;

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Accepted fetches are counted regardless of redirect or stall.
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (i_br_taken) begin
          if ((tgt % WIDTH'(STEP)) != '0) begin
            state_d    = ST_HALT;
            misalign_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
        end else if (!i_stall && xfer) begin
          pc_d = pc_q + WIDTH'(STEP);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    // o_valid is registered and tracks the RUN state exactly.
    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_ADDR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_pc_plus   = pc_q + WIDTH'(STEP);
  assign o_valid     = valid_q;
  assign o_misalign  = misalign_q;
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_contador_programa.sv
// Self-checking bench for contador_programa: directed scenarios followed by
// random stimulus, all compared against a behavioural reference model.
module tb_contador_programa;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned STEP  = 4;
  localparam int unsigned OFF_W = 26;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, br, rel, rdy;
  logic [OFF_W-1:0] off;
  logic [WIDTH-1:0] tgt;

  logic [WIDTH-1:0] o_pc, o_pc_plus;
  logic             o_valid, o_misalign;
  logic [CNT_W-1:0] o_fetch_cnt;

  always #5 clk = ~clk;

  contador_programa #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_ADDR('0), .OFF_W(OFF_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_br_taken(br),
    .i_br_rel(rel), .i_br_offset(off), .i_br_target(tgt), .i_ready(rdy),
    .o_pc(o_pc), .o_pc_plus(o_pc_plus), .o_valid(o_valid),
    .o_misalign(o_misalign), .o_fetch_cnt(o_fetch_cnt)
  );

  // Reference model: phase 0 = boot cycle, 1 = running, 2 = halted.
  int           m_phase;
  logic [63:0]  m_pc;
  bit           m_mis;
  int unsigned  m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic compare_all();
    chk("pc",        o_pc,             m_pc);
    chk("pc_plus",   o_pc_plus,        m_pc + 64'(STEP));
    chk("valid",     64'(o_valid),     64'(m_phase == 1));
    chk("misalign",  64'(o_misalign),  64'(m_mis));
    chk("fetch_cnt", 64'(o_fetch_cnt), 64'(m_cnt));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = '0;
    m_mis   = 1'b0;
    m_cnt   = 0;
  endtask

  // One rising edge worth of architectural behaviour.
  task automatic model_edge();
    logic signed [63:0] disp;
    logic [63:0]        t;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rdy) m_cnt = m_cnt + 1;
      if (br) begin
        disp = 64'($signed(off));
        t    = rel ? (m_pc + 64'(disp * 4)) : tgt;
        if ((t % 64'(STEP)) != 0) begin
          m_phase = 2;
          m_mis   = 1'b1;
        end else begin
          m_pc = t;
        end
      end else if (!stall && rdy) begin
        m_pc = m_pc + 64'(STEP);
      end
    end
  endtask

  task automatic cyc(input logic s, input logic b, input logic r,
                     input logic [OFF_W-1:0] o, input logic [WIDTH-1:0] t,
                     input logic y);
    stall = s; br = b; rel = r; off = o; tgt = t; rdy = y;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0; br = 0; rel = 0; off = '0; tgt = '0; rdy = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; br = 0; rel = 0; off = '0; tgt = '0; rdy = 0;
    model_reset();
    #1 compare_all();
    do_reset();

    // Boot cycle, then four sequential fetches: 0,4,8,C,10.
    cyc(0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, '0, 1);

    // Relative branch -2 words from 0x100, then absolute branch beats stall.
    cyc(0, 1, 0, '0, 64'h100, 0);
    cyc(0, 1, 1, 26'h3FF_FFFE, '0, 0);
    cyc(1, 1, 0, '0, 64'h4000, 1);

    // Stall with ready at 0x20 still counts, ready low without stall holds.
    cyc(0, 1, 0, '0, 64'h20, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0, '0, 1);
    cyc(0, 0, 0, '0, '0, 0);

    // Wrap at the top of the address space and a negative offset from 0.
    cyc(0, 1, 0, '0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    cyc(0, 0, 0, '0, '0, 1);
    cyc(0, 1, 1, 26'h3FF_FFFF, '0, 0);

    // Misaligned absolute redirect halts; later activity is ignored.
    cyc(0, 1, 0, '0, 64'h1002, 1);
    cyc(0, 1, 0, '0, 64'h2000, 1);
    cyc(0, 0, 0, '0, '0, 1);
    cyc(1, 1, 1, 26'h10, '0, 1);
    do_reset();
    cyc(0, 0, 0, '0, '0, 1);
    cyc(0, 0, 0, '0, '0, 1);

    // Asynchronous reset mid-cycle while a redirect is pending.
    stall = 0; br = 1; rel = 0; tgt = 64'h800; rdy = 1;
    #3 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    br = 0;
    cyc(0, 0, 0, '0, '0, 1);
    cyc(0, 0, 0, '0, '0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        logic [WIDTH-1:0] rt;
        rt = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
        cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), OFF_W'($urandom), rt,
            1'($urandom_range(0, 3) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
